// File: rtl/pattern_scan_engine_if.sv
// Request/acknowledge and data-memory bus shared between the processor side
// and the pattern scan engine.
interface pattern_scan_engine_if #(
  parameter int ADDR_W = 8
);
  // req is a start strobe sampled only while the engine is idle or done; ack
  // stays high in DONE until the next accepted req, busy is high otherwise.
  // Reads are combinational (rd_data valid with addr), writes land on the edge.
  logic              req;
  logic              ack;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;

  modport master (
    output req,
    output mem_rd_data,
    input  ack,
    input  busy,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data
  );

  modport slave (
    input  req,
    input  mem_rd_data,
    output ack,
    output busy,
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data
  );
endinterface

// File: rtl/pattern_scan_engine.sv
// Bit-pattern search accelerator: reads a pattern and a byte string from memory,
// counts in-byte, per-byte and cross-byte stream matches, writes three counts back.
module pattern_scan_engine #(
  parameter int ADDR_W    = 8,
  parameter int PAT_W     = 4,
  parameter int NUM_BYTES = 32,
  parameter int SRC_BASE  = 128,
  parameter int PAT_ADDR  = 160,
  parameter int DST_BASE  = 192
) (
  input  logic                clk,
  input  logic                reset,
  pattern_scan_engine_if.slave bus,
  output logic [2:0]          fsm_state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_PAT = 3'd1;
  localparam logic [2:0] SCAN     = 3'd2;
  localparam logic [2:0] WR_CTB   = 3'd3;
  localparam logic [2:0] WR_CTO   = 3'd4;
  localparam logic [2:0] WR_CTS   = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [7:0]        LAST_IDX = 8'(NUM_BYTES - 1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] PAT_A    = ADDR_W'(PAT_ADDR);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);

  logic [2:0]       state;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-2:0] prev;
  logic [7:0]       idx;
  logic [15:0]      ctb;
  logic [15:0]      cto;
  logic [15:0]      cts;

  logic [7:0]       cur;
  logic [PAT_W+6:0] win;
  logic [3:0]       in_cnt;
  logic [3:0]       st_cnt;

  function automatic logic [7:0] sat8(input logic [15:0] c);
    return (c > 16'd255) ? 8'hFF : c[7:0];
  endfunction

  assign cur       = bus.mem_rd_data;
  // Only the low PAT_W-1 bits of the previous byte can reach a window whose LSB is in cur.
  assign win       = {prev, cur};
  assign fsm_state = state;
  assign bus.ack   = (state == DONE);
  assign bus.busy  = (state != IDLE) && (state != DONE);

  // st_cnt counts all 8 windows whose LSB lies in cur; in_cnt keeps those fully inside cur.
  always_comb begin
    in_cnt = 4'd0;
    st_cnt = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (win[k +: PAT_W] == pat) begin
        st_cnt = st_cnt + 4'd1;
        if (k <= 8 - PAT_W) in_cnt = in_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = 8'd0;
    case (state)
      LOAD_PAT: bus.mem_addr = PAT_A;
      SCAN:     bus.mem_addr = SRC_A + ADDR_W'(idx);
      WR_CTB: begin
        bus.mem_addr    = DST_A;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = sat8(ctb);
      end
      WR_CTO: begin
        bus.mem_addr    = DST_A + ADDR_W'(1);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = sat8(cto);
      end
      WR_CTS: begin
        bus.mem_addr    = DST_A + ADDR_W'(2);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = sat8(cts);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pat   <= '0;
      prev  <= '0;
      idx   <= 8'd0;
      ctb   <= 16'd0;
      cto   <= 16'd0;
      cts   <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.req) begin
            state <= LOAD_PAT;
            ctb   <= 16'd0;
            cto   <= 16'd0;
            cts   <= 16'd0;
            prev  <= '0;
          end
        end
        LOAD_PAT: begin
          pat   <= cur[PAT_W-1:0];
          idx   <= 8'd0;
          state <= SCAN;
        end
        SCAN: begin
          ctb  <= ctb + 16'(in_cnt);
          cto  <= cto + 16'(in_cnt != 4'd0);
          // Byte 0 has no predecessor, so its only stream windows are the in-byte ones.
          cts  <= cts + 16'((idx == 8'd0) ? in_cnt : st_cnt);
          prev <= cur[PAT_W-2:0];
          idx  <= idx + 8'd1;
          if (idx == LAST_IDX) state <= WR_CTB;
        end
        WR_CTB:  state <= WR_CTO;
        WR_CTO:  state <= WR_CTS;
        WR_CTS:  state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
